photon_cnt_frame_tx: RTL and testbench
======================================

// Module: photon_cnt_frame_tx
// PURPOSE
//  Consumer end of the photon counter output path. Captures each c_cnt_ready/c_ch1_cnt_output record into a small FIFO.
//  Drains the FIFO as framed bytes over a valid/ready byte stream toward the host link (UART/USB bridge).
//  Frame = SYNC, SEQ, data bytes MSB-first [, CSUM]. Overflow is detected, counted and flagged, never stalls the counter.
// PARAMETERS
//  COUNTSIZE   32     width of each half of the record; must be a multiple of 4; record = 2*COUNTSIZE bits
//  DEPTH_LOG2  4      FIFO depth = 2**DEPTH_LOG2 records
//  SYNC_BYTE   8'hA5  first byte of every frame
// PORTS
//  c_clk             in   1               system clock, single clock domain
//  c_rst_n           in   1               asynchronous, active-low reset
//  c_cnt_ready       in   1               one-cycle strobe: record valid on c_ch1_cnt_output
//  c_ch1_cnt_output  in   2*COUNTSIZE     record {total count, lock-in count}
//  c_clear           in   1               synchronous clear of c_overflow and c_drop_cnt
//  c_tx_data         out  8               stream byte
//  c_tx_valid        out  1               c_tx_data valid
//  c_tx_ready        in   1               sink accepts byte when c_tx_valid && c_tx_ready
//  c_fifo_level      out  DEPTH_LOG2+1    records currently buffered (0..2**DEPTH_LOG2)
//  c_overflow        out  1               sticky: at least one record dropped
//  c_drop_cnt        out  16              dropped-record count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (c_rst_n=0, async): c_tx_data=0, c_tx_valid=0, c_fifo_level=0, c_overflow=0, c_drop_cnt=0; FSM=IDLE; seq=0; FIFO empty.
//  Reset mid-frame abandons the frame; no partial frame is resumed after release.
//  Write: on c_cnt_ready, accept the record if level<DEPTH, or if a pop occurs in the same cycle; otherwise drop it.
//  Drop: c_overflow<=1; c_drop_cnt<=c_drop_cnt+1 (saturating). If c_clear coincides with a drop: c_overflow=1, c_drop_cnt=1.
//  c_clear alone: c_overflow=0, c_drop_cnt=0. Does not affect FIFO contents or frames in progress.
//  FSM states: IDLE, SYNC, SEQ, DATA, CSUM.
//   IDLE -> SYNC when level!=0. Pop the record into a 2*COUNTSIZE shift register. c_tx_data=SYNC_BYTE, c_tx_valid=1.
//   SYNC -> SEQ on handshake; byte = seq.
//   SEQ -> DATA on handshake. DATA emits 2*COUNTSIZE/8 bytes, MSB first; it leaves on the last handshake.
//   After the last byte (DATA, or CSUM when enabled): go to SYNC with an immediate pop if level!=0, otherwise go to IDLE.
//   Back-to-back frames have zero idle cycles. seq increments by 1 mod 256 after each completed frame.
//  Handshake: while c_tx_valid && !c_tx_ready, c_tx_data and c_tx_valid hold stable. c_tx_valid never drops mid-frame.
//  Latency: a strobe in cycle N with the FIFO empty and FSM in IDLE gives level=1 in N+1, pop in N+1, and SYNC valid in N+2.
//  c_fifo_level is registered. A simultaneous push and pop leaves the level unchanged.
//  FIFO pointers are DEPTH_LOG2 bits and wrap naturally. Full/empty are derived from the level counter.
// CONFIGURATION
//  PKT_CHECKSUM_EN defined: a CSUM byte follows the last DATA byte.
//   CSUM = 8-bit sum mod 256 of SEQ and all DATA bytes (SYNC excluded). Frame is 2+2*COUNTSIZE/8+1 bytes (11 at default).
//   The DATA->CSUM->(SYNC|IDLE) path is used.
//  PKT_CHECKSUM_EN undefined: no CSUM state or logic. Frame is 2+2*COUNTSIZE/8 bytes (10 at default). DATA exits directly.
// TESTING
//  T1 single record: push 64'h0102030405060708, c_tx_ready=1.
//     -> A5,00,01,02,03,04,05,06,07,08; with PKT_CHECKSUM_EN also 0x24. SYNC valid exactly 2 cycles after the strobe.
//  T2 backpressure: as T1, toggle c_tx_ready randomly. -> identical byte sequence; data held stable on every stalled cycle.
//  T3 back-to-back: 3 strobes on consecutive cycles. -> 3 frames with SEQ 00,01,02 and no idle cycle between frames.
//     c_fifo_level peaks at 2.
//  T4 overflow: c_tx_ready=0, 20 strobes (DEPTH=16).
//     -> 1 record popped into the frame, 16 buffered, c_drop_cnt=3, c_overflow=1.
//     Release ready: 17 frames out in order. c_clear then gives c_overflow=0, c_drop_cnt=0.
//  T5 full+pop same cycle: FIFO full, strobe on the cycle of a pop -> record accepted, level stays 16, no drop counted.
//  T6 reset mid-frame: assert c_rst_n=0 during DATA byte 3.
//     -> all outputs 0 asynchronously. After release, a new strobe emits a full frame with SEQ=00.
//     Also check seq wrap: after 256 frames, SEQ returns to 00.

Source files
------------

// File: rtl/photon_cnt_frame_tx.sv
// Photon counter record FIFO and byte-stream framer: SYNC, SEQ, record bytes MSB-first.
// Define PKT_CHECKSUM_EN to append a CSUM byte (sum of SEQ and data bytes) to each frame.
module photon_cnt_frame_tx #(
  parameter int          COUNTSIZE  = 32,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                    c_clk,
  input  logic                    c_rst_n,
  input  logic                    c_cnt_ready,
  input  logic [2*COUNTSIZE-1:0]  c_ch1_cnt_output,
  input  logic                    c_clear,
  output logic [7:0]              c_tx_data,
  output logic                    c_tx_valid,
  input  logic                    c_tx_ready,
  output logic [DEPTH_LOG2:0]     c_fifo_level,
  output logic                    c_overflow,
  output logic [15:0]             c_drop_cnt
);
  localparam int RW     = 2 * COUNTSIZE;
  localparam int NBYTES = RW / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int PW     = DEPTH_LOG2;
  localparam int LVLW   = DEPTH_LOG2 + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

`ifdef PKT_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEQ, ST_DATA, ST_CSUM} state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEQ, ST_DATA} state_t;
`endif

  state_t            state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        seq_q, seq_d;
  logic [RW-1:0]     shreg_q, shreg_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVLW-1:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic [RW-1:0]     mem_q [DEPTH];
  logic              hs_s, frame_end_s, pop_s, push_s, drop_s;

  // Next-state: frame sequencing, FIFO bookkeeping and overflow accounting
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    seq_d       = seq_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef PKT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    frame_end_s = 1'b0;
    hs_s        = tx_valid_q && c_tx_ready;

    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
      end
      ST_SYNC: begin
        if (hs_s) begin
          state_d   = ST_SEQ;
          tx_data_d = seq_q;
`ifdef PKT_CHECKSUM_EN
          csum_d    = seq_q;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_SEQ: begin
        if (hs_s) begin
          state_d   = ST_DATA;
          tx_data_d = shreg_q[RW-1 -: 8];
          shreg_d   = shreg_q << 8;
          idx_d     = {IDXW{1'b0}};
`ifdef PKT_CHECKSUM_EN
          csum_d    = csum_add(csum_q, shreg_q[RW-1 -: 8]);
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          if (idx_q == LAST_IDX) begin
`ifdef PKT_CHECKSUM_EN
            state_d   = ST_CSUM;
            tx_data_d = csum_q;
`else
            frame_end_s = 1'b1;
`endif
          end else begin
            tx_data_d = shreg_q[RW-1 -: 8];
            shreg_d   = shreg_q << 8;
            idx_d     = idx_q + IDXW'(1);
`ifdef PKT_CHECKSUM_EN
            csum_d    = csum_add(csum_q, shreg_q[RW-1 -: 8]);
`endif
          end
        end else begin
          state_d = state_q;
        end
      end
`ifdef PKT_CHECKSUM_EN
      ST_CSUM: begin
        if (hs_s) begin
          frame_end_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase

    if (frame_end_s) begin
      seq_d      = seq_q + 8'd1;
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
    end else begin
      seq_d = seq_q;
    end

    // A pop either starts a frame from idle or chains the next frame with no gap
    pop_s  = (level_q != {LVLW{1'b0}}) && ((state_q == ST_IDLE) || frame_end_s);
    push_s = c_cnt_ready && ((level_q != LVLW'(DEPTH)) || pop_s);
    drop_s = c_cnt_ready && !push_s;

    if (pop_s) begin
      state_d    = ST_SYNC;
      tx_data_d  = SYNC_BYTE;
      tx_valid_d = 1'b1;
      shreg_d    = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    level_d = level_q + LVLW'(push_s) - LVLW'(pop_s);

    if (drop_s) begin
      overflow_d = 1'b1;
      if (c_clear) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (c_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      seq_q      <= 8'h00;
      shreg_q    <= {RW{1'b0}};
      idx_q      <= {IDXW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      level_q    <= {LVLW{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      seq_q      <= seq_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Record storage; contents need no reset since the level counter gates reads
  always_ff @(posedge c_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= c_ch1_cnt_output;
    end
  end

  assign c_tx_data    = tx_data_q;
  assign c_tx_valid   = tx_valid_q;
  assign c_fifo_level = level_q;
  assign c_overflow   = overflow_q;
  assign c_drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_photon_cnt_frame_tx.sv
// Bench for photon_cnt_frame_tx: queue-based frame model checked every cycle, plus directed literal checks.
module tb_photon_cnt_frame_tx;
`ifdef PKT_CHECKSUM_EN
  localparam int L = 11;
`else
  localparam int L = 10;
`endif

  logic        clk, rst_n, strobe, clear, ready;
  logic [63:0] rec;
  logic [7:0]  tx_data;
  logic        tx_valid, ovf;
  logic [4:0]  level;
  logic [15:0] drops;

  photon_cnt_frame_tx dut (
    .c_clk(clk), .c_rst_n(rst_n), .c_cnt_ready(strobe), .c_ch1_cnt_output(rec),
    .c_clear(clear), .c_tx_data(tx_data), .c_tx_valid(tx_valid), .c_tx_ready(ready),
    .c_fifo_level(level), .c_overflow(ovf), .c_drop_cnt(drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int peak   = 0;

  logic [63:0] m_rec[$];
  logic [7:0]  m_frame[$];
  logic [7:0]  m_seq;
  logic        m_ovf;
  logic [15:0] m_drops;
  logic [7:0]  cap[$];
  bit          m_hs, m_last, m_pop, m_push;
  logic [63:0] m_r;
  logic [7:0]  m_sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records queue up, each pop expands into the full byte list of its frame
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rec.delete(); m_frame.delete();
      m_seq = 8'h00; m_ovf = 1'b0; m_drops = 16'd0;
    end else begin
      m_hs   = (m_frame.size() != 0) && ready;
      m_last = m_hs && (m_frame.size() == 1);
      m_pop  = (m_rec.size() != 0) && ((m_frame.size() == 0) || m_last);
      m_push = strobe && ((m_rec.size() < 16) || m_pop);
      if (m_hs) void'(m_frame.pop_front());
      if (m_pop) begin
        m_r = m_rec.pop_front();
        m_frame.push_back(8'hA5);
        m_frame.push_back(m_seq);
        m_sum = m_seq;
        for (int i = 0; i < 8; i++) begin
          m_frame.push_back(m_r[63 - 8*i -: 8]);
          m_sum = m_sum + m_r[63 - 8*i -: 8];
        end
`ifdef PKT_CHECKSUM_EN
        m_frame.push_back(m_sum);
`endif
        m_seq = m_seq + 8'd1;
      end
      if (m_push) m_rec.push_back(rec);
      if (strobe && !m_push) begin
        m_ovf = 1'b1;
        m_drops = clear ? 16'd1 : ((m_drops == 16'hFFFF) ? m_drops : m_drops + 16'd1);
      end else if (clear) begin
        m_ovf = 1'b0; m_drops = 16'd0;
      end
    end
  end

  // Byte capture on every accepted handshake
  always @(posedge clk) begin
    if (rst_n && tx_valid && ready) cap.push_back(tx_data);
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("tx_valid", {63'd0, tx_valid}, {63'd0, m_frame.size() != 0});
      if (m_frame.size() != 0) check("tx_data", {56'd0, tx_data}, {56'd0, m_frame[0]});
      check("fifo_level", {59'd0, level}, 64'(m_rec.size()));
      check("overflow", {63'd0, ovf}, {63'd0, m_ovf});
      check("drop_cnt", {48'd0, drops}, {48'd0, m_drops});
      if (int'(level) > peak) peak = int'(level);
    end
  end

  task automatic send(input logic [63:0] r);
    @(negedge clk); strobe = 1'b1; rec = r;
    @(negedge clk); strobe = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!((m_frame.size() == 0) && (m_rec.size() == 0)) && n < budget) begin
      @(negedge clk); n++;
    end
    check("idle_timeout", {63'd0, (m_frame.size() == 0) && (m_rec.size() == 0)}, 64'd1);
  endtask

  task automatic wait_front(input int remaining, input int budget);
    int n = 0;
    while (m_frame.size() != remaining && n < budget) begin
      @(negedge clk); n++;
    end
    check("front_timeout", 64'(m_frame.size()), 64'(remaining));
  endtask

  logic [7:0] exp_t1 [11] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; strobe = 1'b0; clear = 1'b0; ready = 1'b0; rec = 64'd0;
    #3;
    check("rst_data", {56'd0, tx_data}, 64'd0);
    check("rst_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_level", {59'd0, level}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_drops", {48'd0, drops}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; chk_on = 1'b1;

    // T1: single record, latency and literal bytes
    ready = 1'b1; cap.delete();
    send(64'h0102030405060708);
    check("t1_valid_n1", {63'd0, tx_valid}, 64'd0);
    check("t1_level_n1", {59'd0, level}, 64'd1);
    @(negedge clk);
    check("t1_valid_n2", {63'd0, tx_valid}, 64'd1);
    check("t1_sync_n2", {56'd0, tx_data}, 64'hA5);
    wait_idle(60);
    check("t1_len", 64'(cap.size()), 64'(L));
    for (int i = 0; i < L; i++)
      if (i < cap.size()) check("t1_byte", {56'd0, cap[i]}, {56'd0, exp_t1[i]});

    // T2: random backpressure
    cap.delete();
    send(64'h0102030405060708);
    for (int n = 0; n < 400 && !((m_frame.size() == 0) && (m_rec.size() == 0)); n++) begin
      @(negedge clk); ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    wait_idle(60);
    check("t2_len", 64'(cap.size()), 64'(L));
    if (cap.size() >= 10) begin
      check("t2_sync", {56'd0, cap[0]}, 64'hA5);
      check("t2_seq", {56'd0, cap[1]}, 64'h01);
      for (int i = 2; i < 10; i++) check("t2_byte", {56'd0, cap[i]}, {56'd0, exp_t1[i]});
    end

    // T3: three back-to-back strobes
    cap.delete(); peak = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); strobe = 1'b1; rec = {8{8'(8'h11 * (i + 1))}};
    end
    @(negedge clk); strobe = 1'b0;
    wait_idle(100);
    check("t3_peak", 64'(peak), 64'd2);
    check("t3_len", 64'(cap.size()), 64'(3 * L));
    if (cap.size() == 3 * L) begin
      check("t3_seq0", {56'd0, cap[1]}, 64'h02);
      check("t3_seq1", {56'd0, cap[L + 1]}, 64'h03);
      check("t3_seq2", {56'd0, cap[2 * L + 1]}, 64'h04);
      check("t3_data2", {56'd0, cap[2 * L + 2]}, 64'h33);
    end

    // T4: overflow with sink stalled
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); strobe = 1'b1; rec = 64'hA000_0000_0000_0000 + 64'(i);
    end
    @(negedge clk); strobe = 1'b0;
    check("t4_drops", {48'd0, drops}, 64'd3);
    check("t4_ovf", {63'd0, ovf}, 64'd1);
    check("t4_level", {59'd0, level}, 64'd16);
    cap.delete(); ready = 1'b1;
    wait_idle(1000);
    check("t4_len", 64'(cap.size()), 64'(17 * L));
    for (int k = 0; k < 17; k++)
      if (cap.size() == 17 * L) check("t4_order", {56'd0, cap[L * k + 9]}, 64'(k));
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("t4_clr_ovf", {63'd0, ovf}, 64'd0);
    check("t4_clr_drops", {48'd0, drops}, 64'd0);

    // T5: full FIFO with a strobe on the pop cycle
    ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); strobe = 1'b1; rec = 64'hB000_0000_0000_0000 + 64'(i);
    end
    @(negedge clk); strobe = 1'b0;
    check("t5_full", {59'd0, level}, 64'd16);
    ready = 1'b1;
    wait_front(1, 40);
    strobe = 1'b1; rec = 64'hB000_0000_0000_00FF;
    @(negedge clk); strobe = 1'b0;
    check("t5_level", {59'd0, level}, 64'd16);
    check("t5_drops", {48'd0, drops}, 64'd0);
    check("t5_ovf", {63'd0, ovf}, 64'd0);
    wait_idle(1000);

    // Drop coinciding with clear
    ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); strobe = 1'b1; rec = 64'hC000_0000_0000_0000 + 64'(i);
    end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); strobe = 1'b0; clear = 1'b0;
    check("clrdrop_drops", {48'd0, drops}, 64'd1);
    check("clrdrop_ovf", {63'd0, ovf}, 64'd1);
    ready = 1'b1;
    wait_idle(1000);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;

    // T6: reset during DATA byte 3, then seq wrap
    send(64'h1122334455667788);
    wait_front(L - 4, 40);
    #2 rst_n = 1'b0;
    #1;
    check("t6_data", {56'd0, tx_data}, 64'd0);
    check("t6_valid", {63'd0, tx_valid}, 64'd0);
    check("t6_level", {59'd0, level}, 64'd0);
    check("t6_ovf", {63'd0, ovf}, 64'd0);
    check("t6_drops", {48'd0, drops}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    send(64'hDEADBEEF0BADF00D);
    wait_idle(60);
    check("t6_len", 64'(cap.size()), 64'(L));
    if (cap.size() == L) begin
      check("t6_seq", {56'd0, cap[1]}, 64'h00);
      check("t6_d0", {56'd0, cap[2]}, 64'hDE);
    end
    for (int k = 1; k < 256; k++) begin
      send(64'(k));
      wait_idle(60);
    end
    cap.delete();
    send(64'h0000000000000100);
    wait_idle(60);
    if (cap.size() >= 2) check("wrap_seq", {56'd0, cap[1]}, 64'h00);
    else check("wrap_len", 64'(cap.size()), 64'(L));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
